// File: rtl/ccd_seq_pkg.sv
// Shared encodings, default geometry and counter widths for the CCD readout sequencer.
package ccd_seq_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_ARM      = 3'd1;
   localparam logic [2:0] ST_FLUSH    = 3'd2;
   localparam logic [2:0] ST_ACQ_WAIT = 3'd3;
   localparam logic [2:0] ST_ACQ      = 3'd4;
   localparam logic [2:0] ST_DONE     = 3'd5;

   localparam int DEF_PIX_TOTAL = 2052;
   localparam int DEF_PIX_SKIP  = 4;
   localparam int DEF_PIX_VALID = 2048;

   localparam int PIX_CNT_W   = 12;
   localparam int PIX_IDX_W   = 11;
   localparam int FRAME_CNT_W = 8;

   // Pixel counter sticks at all-ones so an overlong frame cannot wrap back into the valid window.
   function automatic logic [PIX_CNT_W-1:0] pix_sat_inc(input logic [PIX_CNT_W-1:0] c);
      return (c == '1) ? c : c + PIX_CNT_W'(1);
   endfunction

endpackage

// File: rtl/ccd_edge_det.sv
// Registered rise/fall detector; a pulse appears one cycle after the input changes.
module ccd_edge_det (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_sig,
   output logic o_rise,
   output logic o_fall
);

   logic sig_q;
   logic sig_dly_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sig_q     <= 1'b0;
         sig_dly_q <= 1'b0;
      end else begin
         sig_q     <= i_sig;
         sig_dly_q <= sig_q;
      end
   end

   assign o_rise = sig_q & ~sig_dly_q;
   assign o_fall = ~sig_q & sig_dly_q;

endmodule

// File: rtl/ccd_readout_sequencer.sv
// Acquisition controller for the CCD clock generator: flush-frame discard, per-pixel ADC strobes, N-frame/continuous runs.
// Optional phi_p watchdog timeout is built only when CCD_SEQ_WATCHDOG_EN is defined.
module ccd_readout_sequencer
   import ccd_seq_pkg::*;
#(
`ifdef CCD_SEQ_WATCHDOG_EN
   parameter logic [31:0] WDOG_CYCLES = 32'h0040_0000,
`endif
   parameter int PIX_TOTAL = DEF_PIX_TOTAL,
   parameter int PIX_SKIP  = DEF_PIX_SKIP,
   parameter int PIX_VALID = DEF_PIX_VALID
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_start,
   input  logic                   i_stop,
   input  logic [3:0]             i_f_select,
   input  logic [7:0]             i_n_frames,
   input  logic                   i_phi_p,
   input  logic                   i_phi_l1,
   output logic                   o_sg_enable,
   output logic [3:0]             o_sg_f_select,
   output logic                   o_sample,
   output logic [PIX_IDX_W-1:0]   o_pix_idx,
   output logic                   o_frame_start,
   output logic [FRAME_CNT_W-1:0] o_frame_cnt,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_error
);

   localparam logic [PIX_CNT_W-1:0] TOTAL_C = PIX_CNT_W'(PIX_TOTAL);
   localparam logic [PIX_CNT_W-1:0] SKIP_C  = PIX_CNT_W'(PIX_SKIP);
   localparam logic [PIX_CNT_W-1:0] END_C   = PIX_CNT_W'(PIX_SKIP + PIX_VALID);

   logic [2:0]             state_q, state_d;
   logic                   en_q, en_d;
   logic [3:0]             fsel_q, fsel_d;
   logic [7:0]             nfr_q, nfr_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d, frame_inc;
   logic [PIX_CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
   logic [PIX_IDX_W-1:0]   pix_idx_q, pix_idx_d;
   logic                   sample_q, sample_d;
   logic                   frame_start_q, frame_start_d;
   logic                   err_q, err_d;
   logic                   stop_q, stop_d;
   logic                   p_rise, p_fall, l1_rise, l1_fall_unused;
   logic                   timeout;

   ccd_edge_det u_phi_p_edge (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_sig   (i_phi_p),
      .o_rise  (p_rise),
      .o_fall  (p_fall)
   );

   ccd_edge_det u_phi_l1_edge (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_sig   (i_phi_l1),
      .o_rise  (l1_rise),
      .o_fall  (l1_fall_unused)
   );

`ifdef CCD_SEQ_WATCHDOG_EN
   logic [31:0] wdog_q, wdog_d;
   logic        wdog_run;

   // Counts cycles since the last phi_p edge while the sequencer is waiting on the generator.
   always_comb begin
      wdog_run = (state_q == ST_ARM) || (state_q == ST_FLUSH) ||
                 (state_q == ST_ACQ_WAIT) || (state_q == ST_ACQ);
      wdog_d   = (!wdog_run || p_rise || p_fall) ? 32'd0 : wdog_q + 32'd1;
      timeout  = wdog_run && !(p_rise || p_fall) && (wdog_q == WDOG_CYCLES - 32'd1);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) wdog_q <= 32'd0;
      else          wdog_q <= wdog_d;
   end
`else
   assign timeout = 1'b0;
`endif

   assign frame_inc = (frame_cnt_q == '1) ? frame_cnt_q : frame_cnt_q + FRAME_CNT_W'(1);

   always_comb begin
      state_d       = state_q;
      en_d          = en_q;
      fsel_d        = fsel_q;
      nfr_d         = nfr_q;
      frame_cnt_d   = frame_cnt_q;
      pix_cnt_d     = pix_cnt_q;
      pix_idx_d     = pix_idx_q;
      sample_d      = 1'b0;
      frame_start_d = 1'b0;
      err_d         = err_q;
      stop_d        = stop_q;

      if (i_stop && (state_q != ST_IDLE)) stop_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               fsel_d      = i_f_select;
               nfr_d       = i_n_frames;
               frame_cnt_d = '0;
               err_d       = 1'b0;
               stop_d      = 1'b0;
               en_d        = 1'b1;
               state_d     = ST_ARM;
            end
         end
         ST_ARM: begin
            if (i_stop || stop_q) state_d = ST_DONE;
            else if (p_fall)      state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (i_stop || stop_q) state_d = ST_DONE;
            else if (p_rise)      state_d = ST_ACQ_WAIT;
         end
         ST_ACQ_WAIT: begin
            if (p_fall) begin
               pix_cnt_d     = '0;
               frame_start_d = 1'b1;
               state_d       = ST_ACQ;
            end
         end
         ST_ACQ: begin
            if (p_rise) begin
               if (pix_cnt_q != TOTAL_C) err_d = 1'b1;
               frame_cnt_d = frame_inc;
               if (((nfr_q != 8'd0) && (frame_inc == nfr_q)) || stop_q || i_stop)
                  state_d = ST_DONE;
               else
                  state_d = ST_ACQ_WAIT;
            end else if (l1_rise) begin
               pix_cnt_d = pix_sat_inc(pix_cnt_q);
               if ((pix_cnt_q >= SKIP_C) && (pix_cnt_q < END_C)) begin
                  sample_d  = 1'b1;
                  pix_idx_d = PIX_IDX_W'(pix_cnt_q - SKIP_C);
               end
            end
         end
         ST_DONE: begin
            stop_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (timeout) begin
         err_d   = 1'b1;
         state_d = ST_DONE;
      end

      // The generator is released the moment the run is over, so DONE already sees it disabled.
      if (state_d == ST_DONE) en_d = 1'b0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= ST_IDLE;
         en_q          <= 1'b0;
         fsel_q        <= 4'd0;
         nfr_q         <= 8'd0;
         frame_cnt_q   <= '0;
         pix_cnt_q     <= '0;
         pix_idx_q     <= '0;
         sample_q      <= 1'b0;
         frame_start_q <= 1'b0;
         err_q         <= 1'b0;
         stop_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         en_q          <= en_d;
         fsel_q        <= fsel_d;
         nfr_q         <= nfr_d;
         frame_cnt_q   <= frame_cnt_d;
         pix_cnt_q     <= pix_cnt_d;
         pix_idx_q     <= pix_idx_d;
         sample_q      <= sample_d;
         frame_start_q <= frame_start_d;
         err_q         <= err_d;
         stop_q        <= stop_d;
      end
   end

   assign o_sg_enable   = en_q;
   assign o_sg_f_select = fsel_q;
   assign o_sample      = sample_q;
   assign o_pix_idx     = pix_idx_q;
   assign o_frame_start = frame_start_q;
   assign o_frame_cnt   = frame_cnt_q;
   assign o_busy        = (state_q != ST_IDLE);
   assign o_done        = (state_q == ST_DONE);
   assign o_error       = err_q;

endmodule

// File: tb/tb_ccd_readout_sequencer.sv
// Self-checking bench for ccd_readout_sequencer with a behavioural clock-generator model and a sample scoreboard.
module tb_ccd_readout_sequencer;

   localparam int SKIP  = 4;
   localparam int VALID = 2048;
   localparam int TOTAL = 2052;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [3:0]  fsel = 4'd0;
   logic [7:0]  nfr = 8'd0;
   logic        phi_p;
   logic        phi_l1;
   logic        o_sg_enable;
   logic [3:0]  o_sg_f_select;
   logic        o_sample;
   logic [10:0] o_pix_idx;
   logic        o_frame_start;
   logic [7:0]  o_frame_cnt;
   logic        o_busy;
   logic        o_done;
   logic        o_error;

   int checks = 0;
   int passes = 0;
   int expQ[$];
   int genPix[0:7];
   bit genHoldP = 1'b0;
   int genFrame = 0;

   always #5 clk = ~clk;

   ccd_readout_sequencer #(
`ifdef CCD_SEQ_WATCHDOG_EN
      .WDOG_CYCLES (32'd100),
`endif
      .PIX_TOTAL   (TOTAL),
      .PIX_SKIP    (SKIP),
      .PIX_VALID   (VALID)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_start       (start),
      .i_stop        (stop),
      .i_f_select    (fsel),
      .i_n_frames    (nfr),
      .i_phi_p       (phi_p),
      .i_phi_l1      (phi_l1),
      .o_sg_enable   (o_sg_enable),
      .o_sg_f_select (o_sg_f_select),
      .o_sample      (o_sample),
      .o_pix_idx     (o_pix_idx),
      .o_frame_start (o_frame_start),
      .o_frame_cnt   (o_frame_cnt),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_error       (o_error)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Generator model: phi_p pulse, then genPix[frame] phi_l1 periods; frame 0 is the flush frame.
   initial begin : generator
      phi_p  = 1'b0;
      phi_l1 = 1'b0;
      forever begin
         tick();
         if (o_sg_enable) begin
            bit active;
            active   = 1'b1;
            genFrame = 0;
            while (active) begin
               phi_p = 1'b1;
               repeat (4) tick();
               if (!o_sg_enable) active = 1'b0;
               else begin
                  phi_p = 1'b0;
                  if (genHoldP) begin
                     while (o_sg_enable) tick();
                     active = 1'b0;
                  end else begin
                     repeat (2) tick();
                     for (int c = 0; c < genPix[genFrame] && active; c++) begin
                        if (!o_sg_enable) active = 1'b0;
                        else begin
                           phi_l1 = 1'b1;
                           if (genFrame >= 1 && c >= SKIP && c < SKIP + VALID) expQ.push_back(c - SKIP);
                           tick();
                           phi_l1 = 1'b0;
                           tick();
                        end
                     end
                     if (active) begin
                        repeat (2) tick();
                        if (genFrame < 7) genFrame++;
                     end
                  end
               end
            end
            phi_p  = 1'b0;
            phi_l1 = 1'b0;
         end
      end
   end

   task automatic setFrames(input int frame1Pix);
      for (int i = 0; i < 8; i++) genPix[i] = TOTAL;
      genPix[1] = frame1Pix;
      expQ.delete();
   endtask

   task automatic applyStart(input logic [3:0] fs, input logic [7:0] nf);
      repeat (3) tick();
      start = 1'b1;
      fsel  = fs;
      nfr   = nf;
      tick();
      start = 1'b0;
   endtask

   // Runs until o_done (or stopAfter samples), scoring every o_sample against the scoreboard.
   task automatic runAndScore(input int budget, input int stopAfter, input int stopPulseAt,
                              output int nS, output int nFs, output int nD);
      bit   finished = 1'b0;
      int   stopSent = 0;
      logic [10:0] expIdx;
      nS = 0; nFs = 0; nD = 0;
      for (int cyc = 0; cyc < budget && !finished; cyc++) begin
         @(negedge clk);
         if (stopSent == 1) begin
            stop     = 1'b0;
            stopSent = 2;
         end
         if (o_sample) begin
            nS++;
            checks++;
            if (expQ.size() == 0)
               $display("[TB] FAIL sample_unexpected: got idx %0d, scoreboard empty", o_pix_idx);
            else begin
               expIdx = 11'(expQ.pop_front());
               if (o_pix_idx !== expIdx)
                  $display("[TB] FAIL pix_idx: got %0d expected %0d", o_pix_idx, expIdx);
               else passes++;
            end
         end
         if (o_frame_start) nFs++;
         if (o_done) begin
            nD++;
            finished = 1'b1;
         end
         if (stopPulseAt > 0 && nS == stopPulseAt && stopSent == 0) begin
            stop     = 1'b1;
            stopSent = 1;
         end
         if (stopAfter > 0 && nS >= stopAfter) finished = 1'b1;
      end
      stop = 1'b0;
      checks++;
      if (!finished) $display("[TB] FAIL run_timeout: got no completion within %0d cycles, required completion", budget);
      else passes++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({o_sg_enable, o_sg_f_select, o_sample, o_pix_idx, o_frame_start, o_frame_cnt, o_busy, o_done, o_error} !== 29'd0)
         $display("[TB] FAIL reset_outputs: got en=%b busy=%b cnt=%0d err=%b, required all 0", o_sg_enable, o_busy, o_frame_cnt, o_error);
      else passes++;
      tick();
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (o_busy !== 1'b0) $display("[TB] FAIL idle_after_reset: got busy %b expected 0", o_busy);
      else passes++;
   endtask

   task automatic test_capture();
      int nS, nFs, nD, extraDone;
      setFrames(TOTAL);
      repeat (3) tick();
      start = 1'b1; fsel = 4'd3; nfr = 8'd2;
      @(negedge clk);
      checks++;
      if (o_sg_enable !== 1'b0) $display("[TB] FAIL enable_before_start: got %b expected 0", o_sg_enable);
      else passes++;
      tick();
      start = 1'b0;
      fsel  = 4'd9;
      @(negedge clk);
      checks++;
      if (o_sg_enable !== 1'b1 || o_busy !== 1'b1)
         $display("[TB] FAIL enable_after_start: got en=%b busy=%b expected 1/1", o_sg_enable, o_busy);
      else passes++;
      runAndScore(20000, 0, 0, nS, nFs, nD);
      checks++;
      if (nS !== 2 * VALID) $display("[TB] FAIL capture_samples: got %0d expected %0d", nS, 2 * VALID);
      else passes++;
      checks++;
      if (nFs !== 2) $display("[TB] FAIL capture_frame_starts: got %0d expected 2", nFs);
      else passes++;
      checks++;
      if (o_frame_cnt !== 8'd2) $display("[TB] FAIL capture_frame_cnt: got %0d expected 2", o_frame_cnt);
      else passes++;
      checks++;
      if (o_sg_f_select !== 4'd3) $display("[TB] FAIL f_select_latched: got %0d expected 3", o_sg_f_select);
      else passes++;
      checks++;
      if (o_sg_enable !== 1'b0 || o_error !== 1'b0)
         $display("[TB] FAIL capture_end_state: got en=%b err=%b expected 0/0", o_sg_enable, o_error);
      else passes++;
      checks++;
      if (expQ.size() != 0) $display("[TB] FAIL capture_missing_samples: got %0d left expected 0", expQ.size());
      else passes++;
      extraDone = 0;
      repeat (6) begin
         @(negedge clk);
         if (o_done) extraDone++;
      end
      checks++;
      if (extraDone != 0 || o_busy !== 1'b0)
         $display("[TB] FAIL done_single_pulse: got extra=%0d busy=%b expected 0/0", extraDone, o_busy);
      else passes++;
   endtask

   task automatic test_pix_error();
      int nS, nFs, nD, total;
      setFrames(2050);
      applyStart(4'd1, 8'd2);
      runAndScore(10000, VALID - 2, 0, nS, nFs, nD);
      total = nS;
      checks++;
      if (o_error !== 1'b0) $display("[TB] FAIL error_early: got %b expected 0", o_error);
      else passes++;
      runAndScore(100, 1, 0, nS, nFs, nD);
      total += nS;
      checks++;
      if (o_error !== 1'b1) $display("[TB] FAIL error_after_short_frame: got %b expected 1", o_error);
      else passes++;
      runAndScore(10000, 0, 0, nS, nFs, nD);
      total += nS;
      checks++;
      if (total !== 2 * VALID - 2 || o_frame_cnt !== 8'd2 || o_error !== 1'b1)
         $display("[TB] FAIL error_run: got samples=%0d cnt=%0d err=%b expected %0d/2/1", total, o_frame_cnt, o_error, 2 * VALID - 2);
      else passes++;
   endtask

   task automatic test_continuous_stop();
      int nS, nFs, nD;
      setFrames(TOTAL);
      applyStart(4'd2, 8'd0);
      @(negedge clk);
      checks++;
      if (o_error !== 1'b0) $display("[TB] FAIL error_cleared_on_start: got %b expected 0", o_error);
      else passes++;
      runAndScore(25000, 0, 2 * VALID + 1000, nS, nFs, nD);
      checks++;
      if (nS !== 3 * VALID || nFs !== 3 || o_frame_cnt !== 8'd3)
         $display("[TB] FAIL continuous_stop: got samples=%0d starts=%0d cnt=%0d expected %0d/3/3", nS, nFs, o_frame_cnt, 3 * VALID);
      else passes++;
      checks++;
      if (expQ.size() != 0) $display("[TB] FAIL continuous_missing_samples: got %0d left expected 0", expQ.size());
      else passes++;
   endtask

   task automatic test_stop_flush();
      int  nSamp = 0;
      bit  seenDone = 1'b0;
      setFrames(TOTAL);
      applyStart(4'd7, 8'd0);
      repeat (12) begin
         @(negedge clk);
         if (o_sample) nSamp++;
      end
      stop = 1'b1;
      for (int k = 0; k < 2 && !seenDone; k++) begin
         @(negedge clk);
         stop = 1'b0;
         if (o_sample) nSamp++;
         if (o_done) seenDone = 1'b1;
      end
      stop = 1'b0;
      checks++;
      if (!seenDone) $display("[TB] FAIL stop_flush_done: got no o_done within 2 cycles, required o_done");
      else passes++;
      checks++;
      if (nSamp != 0 || o_frame_cnt !== 8'd0 || o_sg_enable !== 1'b0)
         $display("[TB] FAIL stop_flush_state: got samples=%0d cnt=%0d en=%b expected 0/0/0", nSamp, o_frame_cnt, o_sg_enable);
      else passes++;
   endtask

   task automatic test_reset_midrun();
      int nS, nFs, nD;
      setFrames(TOTAL);
      applyStart(4'd5, 8'd1);
      runAndScore(10000, 1000 - SKIP, 0, nS, nFs, nD);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({o_sg_enable, o_sg_f_select, o_sample, o_pix_idx, o_frame_start, o_frame_cnt, o_busy, o_done, o_error} !== 29'd0)
         $display("[TB] FAIL reset_midrun_outputs: got en=%b busy=%b idx=%0d, required all 0", o_sg_enable, o_busy, o_pix_idx);
      else passes++;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      expQ.delete();
      applyStart(4'd5, 8'd1);
      runAndScore(12000, 0, 0, nS, nFs, nD);
      checks++;
      if (nS !== VALID || o_frame_cnt !== 8'd1 || o_error !== 1'b0)
         $display("[TB] FAIL rerun_after_reset: got samples=%0d cnt=%0d err=%b expected %0d/1/0", nS, o_frame_cnt, o_error, VALID);
      else passes++;
   endtask

`ifdef CCD_SEQ_WATCHDOG_EN
   task automatic test_watchdog();
      int  cyc = 0;
      bit  seenDone = 1'b0;
      setFrames(TOTAL);
      genHoldP = 1'b1;
      applyStart(4'd0, 8'd1);
      while (cyc < 400 && !seenDone) begin
         @(negedge clk);
         cyc++;
         if (o_done) seenDone = 1'b1;
      end
      checks++;
      if (!seenDone || cyc < 100 || cyc > 120)
         $display("[TB] FAIL watchdog_timing: got done=%b at cycle %0d expected done in 100..120", seenDone, cyc);
      else passes++;
      checks++;
      if (o_error !== 1'b1) $display("[TB] FAIL watchdog_error: got %b expected 1", o_error);
      else passes++;
      genHoldP = 1'b0;
   endtask
`endif

   initial begin
      for (int i = 0; i < 8; i++) genPix[i] = TOTAL;
      $display("[TB] starting ccd_readout_sequencer bench");
      test_reset();
      test_capture();
      test_pix_error();
      test_continuous_stop();
      test_stop_flush();
      test_reset_midrun();
`ifdef CCD_SEQ_WATCHDOG_EN
      test_watchdog();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/ccd_readout_sequencer.md
Name: ccd_readout_sequencer

Overview:
- Acquisition controller for the CCD clock generator, the block that drives phi_p/phi_l1/phi_l2/phi_r.
- Drives the generator's enable and frequency-select inputs and watches its phi_p/phi_l1 outputs to find frame and pixel boundaries.
- Issues one ADC sample strobe per valid pixel and runs host start/stop/done handshakes for N-frame or continuous capture.
- Discards the first (flush) frame after each enable.

Parameters:
PIX_TOTAL, 2052, phi_l1 shift periods per frame expected from the generator
PIX_SKIP, 4, leading dummy pixels not sampled
PIX_VALID, 2048, pixels sampled per frame after skip
WDOG_CYCLES, 32'h0040_0000, max cycles between phi_p edges (watchdog build only)

Ports:
i_clk  in  1  system clock, shared with the generator
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  1-cycle pulse; ignored unless IDLE
i_stop  in  1  1-cycle pulse; request stop at the next frame boundary
i_f_select  in  4  integration select, latched on accepted start
i_n_frames  in  8  frames to capture, latched on start; 0 = continuous
i_phi_p  in  1  generator phi_p
i_phi_l1  in  1  generator phi_l1
o_sg_enable  out  1  generator enable
o_sg_f_select  out  4  latched i_f_select
o_sample  out  1  ADC sample strobe, 1 cycle
o_pix_idx  out  11  valid pixel index 0..PIX_VALID-1, held with o_sample
o_frame_start  out  1  1-cycle pulse at start of each captured frame
o_frame_cnt  out  8  captured frames in the current run
o_busy  out  1  high in every state except IDLE
o_done  out  1  1-cycle pulse on run completion
o_error  out  1  sticky; cleared on accepted start

Behaviour:
- Reset (async, i_rst_n low): state IDLE. All outputs 0. Counters, edge-detect registers and latched values cleared. Reset mid-run aborts immediately and drops o_sg_enable.
- Edge detect: registered copies of i_phi_p/i_phi_l1, same clock domain, no synchronizer. An edge is visible one cycle after the input changes.
- States:
  - IDLE: on i_start, latch f_select and n_frames, clear o_frame_cnt and o_error, set o_sg_enable=1, go ARM.
  - ARM: wait for phi_p fall, i.e. the start of the flush shift, then go FLUSH.
  - FLUSH: no samples. On phi_p rise go ACQ_WAIT.
  - ACQ_WAIT: on phi_p fall: clear pixel counter, pulse o_frame_start, go ACQ.
  - ACQ: on each phi_l1 rise, pix_cnt++. If the pre-increment count c satisfies PIX_SKIP <= c < PIX_SKIP+PIX_VALID, o_sample=1 on the next cycle with o_pix_idx=c-PIX_SKIP. On phi_p rise the frame is ended: if pix_cnt != PIX_TOTAL set o_error; o_frame_cnt++ (saturates at 255). Then go DONE if (n_frames!=0 and new count==n_frames) or stop is pending; otherwise go ACQ_WAIT.
  - DONE: o_sg_enable=0, o_done=1 for exactly one cycle, then IDLE.
- Stop handling: i_stop sets a stop_pending flag. In ARM or FLUSH it goes DONE on the next cycle with no frame counted. In ACQ/ACQ_WAIT it takes effect at the next frame end. A stop pulse in IDLE is ignored.
- Simultaneous start and stop in IDLE: start is accepted, the stop is ignored.
- o_sg_f_select is constant while busy. The generator samples it only at its pulse-to-shift transition, so mid-run changes on i_f_select have no effect.
- pix_cnt is 12 bits and saturates at 4095. A count above PIX_TOTAL only raises an error at frame end.

Optional Feature:
- Macro CCD_SEQ_WATCHDOG_EN.
- With the macro: a 32-bit counter reloads on every phi_p edge and runs in ARM/FLUSH/ACQ_WAIT/ACQ. On reaching WDOG_CYCLES: set o_error, go DONE, pulse o_done.
- Without the macro: no counter and no timeout; the sequencer waits indefinitely.

Decomposition:
- Package ccd_seq_pkg holds:
  - the 3-bit state encoding (IDLE, ARM, FLUSH, ACQ_WAIT, ACQ, DONE);
  - default constants PIX_TOTAL/PIX_SKIP/PIX_VALID;
  - the pixel-counter and frame-counter widths.
- One sub-module, ccd_edge_det: registered rise/fall pulse generator, instantiated for phi_p and phi_l1.

Test Plan:
1. Reset, then start with n_frames=2, f_select=3, bench generator model attached:
   - o_sg_enable rises the cycle after start;
   - flush frame produces no o_sample;
   - 2 frames × 2048 o_sample pulses, o_pix_idx 0..2047 in order;
   - o_frame_cnt=2, one o_done pulse, o_sg_enable low.
2. Model emits 2050 phi_l1 periods in frame 1 -> o_error=1 after frame end; the run continues to o_done.
3. n_frames=0, i_stop pulsed mid-frame 3 -> frame 3 completes with 2048 samples, o_frame_cnt=3, o_done.
4. i_stop during FLUSH -> no o_sample, o_frame_cnt=0, o_done within 2 cycles.
5. i_rst_n low for 1 cycle during ACQ at pixel 1000 -> all outputs 0 immediately; a subsequent start runs cleanly.
6. CCD_SEQ_WATCHDOG_EN defined, WDOG_CYCLES=100, phi_p held low -> o_error=1 and o_done 100 cycles after the last phi_p edge.
